// File: rtl/serial_pkg.sv
// Field widths shared by the serial message front end.
// Each capture register instance uses one of these as its width.
package serial_pkg;

    localparam int PORT_W = 2;
    localparam int LEN_W  = 4;
    localparam int WORD_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a registered at-max flag.
// Clear wins over load_max, and load_max wins over inc; nothing changes while en is low.
module sat_counter #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic         load_max,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q, count_d;
    logic         at_max_q, at_max_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            if (clear)
                count_d = '0;
            else if (load_max)
                count_d = MAX_V;
            else if (inc && (count_q != MAX_V))
                count_d = count_q + 1'b1;
        end
        // at_max is registered from the next count so it never lags count.
        at_max_d = (count_d == MAX_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            at_max_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_max_q <= at_max_d;
        end
    end

    assign count  = count_q;
    assign at_max = at_max_q;

endmodule

// File: rtl/serial_shift_capture.sv
// Serial-to-parallel capture register with a bit-order option, parallel load, clear and serial-out.
// A bit counter reports when the field is full and pulses done on the shift that fills it.
module serial_shift_capture
    import serial_pkg::*;
#(
    parameter int WIDTH     = PORT_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clkEN,
    input  logic             sh_en,
    input  logic             SerIn,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] par_in,
    input  logic             clr,
    output logic [WIDTH-1:0] par_out,
    output logic             SerOut,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             done
);

    localparam logic [CW-1:0] LAST_V = CW'(WIDTH - 1);

    logic [WIDTH-1:0] field_q, field_d;
    logic [WIDTH-1:0] shifted;
    logic             done_q, done_d;
    logic [CW-1:0]    count_w;
    logic             full_w;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {field_q[WIDTH-2:0], SerIn};
            assign SerOut  = field_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shifted = {SerIn, field_q[WIDTH-1:1]};
            assign SerOut  = field_q[0];
        end
    endgenerate

    always_comb begin
        field_d = field_q;
        done_d  = 1'b0;
        if (clkEN) begin
            if (clr) begin
                field_d = '0;
            end else if (ld_en) begin
                field_d = par_in;
            end else if (sh_en) begin
                field_d = shifted;
                // Only the shift that moves count from WIDTH-1 to WIDTH fires done.
                done_d  = (count_w == LAST_V);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            field_q <= '0;
            done_q  <= 1'b0;
        end else begin
            field_q <= field_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(
        .MAX (WIDTH),
        .W   (CW)
    ) u_counter (
        .clk      (clock),
        .rst      (reset),
        .en       (clkEN),
        .clear    (clr),
        .load_max (ld_en),
        .inc      (sh_en),
        .count    (count_w),
        .at_max   (full_w)
    );

    assign par_out = field_q;
    assign count   = count_w;
    assign full    = full_w;
    assign done    = done_q;

endmodule
